// File: rtl/riscv_dcache_pkg.sv
// Shared types for the L1 data cache miss controller.
package riscv_dcache_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      ALLOCATE,
      UPDATE
   } dcache_state_e;

   localparam int unsigned DCACHE_BEATS = 4;

endpackage

// File: rtl/riscv_dcache_ctrl_if.sv
// Burst handshake between the dcache miss controller and the next memory level.
interface riscv_dcache_ctrl_if #(
   parameter int unsigned CNT_W = 2
);
   logic             mem_rd_req;
   logic             mem_wr_req;
   logic             mem_ack;
   logic             addr_sel_old;
   logic             refill_we;
   logic [CNT_W-1:0] beat_cnt;

   modport master (
      output mem_rd_req, mem_wr_req, addr_sel_old, refill_we, beat_cnt,
      input  mem_ack
   );

   modport slave (
      input  mem_rd_req, mem_wr_req, addr_sel_old, refill_we, beat_cnt,
      output mem_ack
   );
endinterface

// File: rtl/riscv_dcache_beat_cnt.sv
// Beat offset within a cache line; wraps on the last beat of a burst.
module riscv_dcache_beat_cnt #(
   parameter int unsigned CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   input  logic             clear,
   output logic [CNT_W-1:0] cnt,
   output logic             last
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (inc) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == '1);

endmodule

// File: rtl/riscv_dcache_ctrl.sv
// Write-back, write-allocate L1 dcache miss controller: hit handling,
// victim writeback, line refill and tag update.
module riscv_dcache_ctrl
   import riscv_dcache_pkg::*;
#(
   parameter int unsigned BEATS = DCACHE_BEATS,
   parameter int unsigned CNT_W = $clog2(BEATS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpu_rd_req,
   input  logic                cpu_wr_req,
   input  logic                hit,
   input  logic                dirty,
   output logic                stall,
   output logic                replace_tag,
   output logic                valid_in,
   output logic                dirty_in,
   output logic                cpu_data_we,
   riscv_dcache_ctrl_if.master mem
);

   dcache_state_e    state_q;
   dcache_state_e    state_d;
   logic             cnt_inc;
   logic             cnt_last;
   logic [CNT_W-1:0] cnt;

   riscv_dcache_beat_cnt #(.CNT_W(CNT_W)) u_beat_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc),
      .clear (cnt_inc && cnt_last),
      .cnt   (cnt),
      .last  (cnt_last)
   );

   assign mem.beat_cnt = cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs are forced low during reset so nothing reaches the arrays or memory.
   always_comb begin
      state_d          = state_q;
      cnt_inc          = 1'b0;
      stall            = 1'b0;
      replace_tag      = 1'b0;
      valid_in         = 1'b0;
      dirty_in         = 1'b0;
      cpu_data_we      = 1'b0;
      mem.mem_rd_req   = 1'b0;
      mem.mem_wr_req   = 1'b0;
      mem.addr_sel_old = 1'b0;
      mem.refill_we    = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            IDLE: begin
               if (cpu_rd_req || cpu_wr_req) begin
                  if (hit) begin
                     if (cpu_wr_req) begin
                        cpu_data_we = 1'b1;
                        replace_tag = 1'b1;
                        valid_in    = 1'b1;
                        dirty_in    = 1'b1;
                     end
                  end else begin
                     stall   = 1'b1;
                     state_d = dirty ? WRITEBACK : ALLOCATE;
                  end
               end
            end
            WRITEBACK: begin
               stall            = 1'b1;
               mem.mem_wr_req   = 1'b1;
               mem.addr_sel_old = 1'b1;
               cnt_inc          = mem.mem_ack;
               if (mem.mem_ack && cnt_last) begin
                  state_d = ALLOCATE;
               end
            end
            ALLOCATE: begin
               stall          = 1'b1;
               mem.mem_rd_req = 1'b1;
               mem.refill_we  = mem.mem_ack;
               cnt_inc        = mem.mem_ack;
               if (mem.mem_ack && cnt_last) begin
                  state_d = UPDATE;
               end
            end
            UPDATE: begin
               stall       = 1'b1;
               replace_tag = 1'b1;
               valid_in    = 1'b1;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule
